agat9_kbd_scan_ctrl: RTL

Scan sequencer for the Agat-9 key matrix. It drives one matrix input (column) low at a time and samples the 16 pulled-up matrix outputs (rows). Each key is debounced over two scan frames. Press and release events are queued into a FIFO as 8-bit key codes, and the downstream serializer drains that FIFO over a valid/ready handshake.

---
 rtl/agat9_kbd_scan_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/agat9_kbd_scan_ctrl.sv
// Agat-9 key matrix scan sequencer: drives one column low at a time, debounces each key
// over two frame samples and queues press/release codes into a fall-through FIFO.
module agat9_kbd_scan_ctrl #(
  parameter int COLS       = 6,
  parameter int SETTLE     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            scan_en,
  output logic [COLS-1:0] col_drv_n,
  input  logic [15:0]     row_sense_n,
  output logic [7:0]      code_data,
  output logic            code_valid,
  input  logic            code_ready,
  output logic            frame_done,
  output logic            busy,
  output logic [2:0]      dbg_state
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SAMPLE = 3'd2,
    EMIT   = 3'd3,
    NEXT   = 3'd4
  } state_t;

  state_t               state, state_d;
  logic [SW-1:0]        settle_cnt;
  logic [2:0]           col;
  logic [3:0]           row_idx;
  logic [15:0]          cur;
  logic [COLS*16-1:0]   sample_prev;
  logic [COLS*16-1:0]   stable;

  logic [7:0]           fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [PW:0]          fifo_cnt;
  logic                 fifo_full;

  logic [6:0]           key_idx;
  logic                 s_bit, prev_bit, stab_bit;
  logic                 press_ev, release_ev, key_ev;
  logic                 stall, row_step, push, pop, last_col;
  logic [COLS-1:0]      col_onehot;

  // Handshake: a code transfers on any clock edge where code_valid & code_ready are both 1;
  // code_data stays stable while code_valid=1 and code_ready=0.
  assign key_idx    = {col, row_idx};
  assign s_bit      = cur[row_idx];
  assign prev_bit   = sample_prev[key_idx];
  assign stab_bit   = stable[key_idx];
  assign press_ev   = s_bit & prev_bit & ~stab_bit;
  assign release_ev = ~s_bit & ~prev_bit & stab_bit;
  assign key_ev     = press_ev | release_ev;
  assign stall      = (state == EMIT) & key_ev & fifo_full;
  assign row_step   = (state == EMIT) & ~stall;
  assign push       = row_step & key_ev;
  assign pop        = code_valid & code_ready;
  assign last_col   = (col == 3'(COLS - 1));
  assign col_onehot = COLS'(1) << col;

  assign fifo_full  = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
  assign code_valid = (fifo_cnt != '0);
  assign code_data  = code_valid ? fifo_mem[rd_ptr] : 8'h00;
  assign dbg_state  = state;

  always_comb begin
    state_d    = state;
    col_drv_n  = '1;
    frame_done = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (scan_en) state_d = DRIVE;
      end
      DRIVE: begin
        col_drv_n = ~col_onehot;
        if (settle_cnt == '0) state_d = SAMPLE;
      end
      SAMPLE: begin
        col_drv_n = ~col_onehot;
        state_d   = EMIT;
      end
      EMIT: begin
        col_drv_n = ~col_onehot;
        if (row_step && row_idx == 4'd15) state_d = NEXT;
      end
      NEXT: begin
        frame_done = last_col;
        state_d    = scan_en ? DRIVE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      col         <= '0;
      row_idx     <= '0;
      cur         <= '0;
      sample_prev <= '0;
      stable      <= '0;
    end else begin
      state <= state_d;
      if (state_d == DRIVE && state != DRIVE)
        settle_cnt <= SW'(SETTLE - 1);
      else if (state == DRIVE && settle_cnt != '0)
        settle_cnt <= settle_cnt - 1'b1;
      if (state == SAMPLE) begin
        cur     <= ~row_sense_n;
        row_idx <= '0;
      end
      // A stalled row keeps its history so the pending event is retried unchanged.
      if (row_step) begin
        row_idx              <= row_idx + 4'd1;
        sample_prev[key_idx] <= s_bit;
        if (key_ev) stable[key_idx] <= ~stab_bit;
      end
      if (state == NEXT) col <= last_col ? 3'd0 : col + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {release_ev, col, row_idx};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule
